// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch controller: opcodes, opcode
// field bounds, FSM state encoding and the unconditional-jump predecoder.
package fetch_pkg;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;

  localparam logic [1:0] S_FETCH_ENC  = 2'd0;
  localparam logic [1:0] S_FULL_ENC   = 2'd1;
  localparam logic [1:0] S_HALTED_ENC = 2'd2;

  typedef enum logic [1:0] {
    S_FETCH  = S_FETCH_ENC,
    S_FULL   = S_FULL_ENC,
    S_HALTED = S_HALTED_ENC
  } fetch_state_e;

  // j and jal redirect fetch immediately; everything else falls through.
  function automatic logic is_uncond_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JAL);
  endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the memory, redirect and decode-side signals of the fetch
// controller. master = fetch controller, slave = memory/execute/decode side.
interface imem_fetch_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_data;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              halted;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_data, redir_valid, redir_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_data, redir_valid, redir_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO holding {pc, instr} pairs. Flush beats push
// and pop. Read data comes straight from registered storage.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 40,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop   = i_pop  && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: owns the pc, predecodes j/jal so fetch
// follows them without a bubble, queues {pc, instr} toward decode and
// takes redirects from execute. Optional self-jump halt detection is
// enabled with FETCH_HALT_DETECT_EN.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int CW    = ((DEPTH > 1) ? $clog2(DEPTH) : 1) + 1
) (
  input  logic              clk,
  input  logic              rst,
  imem_fetch_ctrl_if.master bus
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_next_pc;
  logic [5:0]        w_op;
  logic              w_jump;
  logic              w_self_jump;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_count_nxt;
  logic [ADDR_W+DATA_W-1:0] w_rdata;

  assign w_op      = bus.imem_data[OP_HI:OP_LO];
  assign w_jump    = is_uncond_jump(w_op);
  assign w_next_pc = w_jump ? bus.imem_data[ADDR_W-1:0] : r_pc + 1'b1;
  assign w_pop     = bus.out_valid && bus.out_ready;

`ifdef FETCH_HALT_DETECT_EN
  assign w_self_jump = (w_op == OP_J) && (bus.imem_data[ADDR_W-1:0] == r_pc);
`else
  assign w_self_jump = 1'b0;
`endif

  assign w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_nxt;
  end

  // Next state: redirect wins; a pushed self-jump halts; otherwise track fullness.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.redir_valid) begin
      w_state_nxt = S_FETCH;
    end else begin
      case (r_state)
        S_FETCH, S_FULL: begin
          if (w_push && w_self_jump)          w_state_nxt = S_HALTED;
          else if (w_count_nxt == CW'(DEPTH)) w_state_nxt = S_FULL;
          else                                w_state_nxt = S_FETCH;
        end
        S_HALTED: w_state_nxt = S_HALTED;
        default:  w_state_nxt = S_FETCH;
      endcase
    end
  end

  // Outputs: fetch whenever there is room after this cycle's pop, unless halted
  // or being redirected (the fetched word is then discarded).
  always_comb begin
    w_push     = 1'b0;
    bus.halted = 1'b0;
    if (r_state != S_HALTED && (!w_full || w_pop) && !bus.redir_valid)
      w_push = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
    bus.halted = (r_state == S_HALTED);
`endif
  end

  // Program counter: only moves on a push or a redirect.
  always_ff @(posedge clk) begin
    if (rst)                  r_pc <= '0;
    else if (bus.redir_valid) r_pc <= bus.redir_pc;
    else if (w_push)          r_pc <= w_next_pc;
  end

  assign bus.imem_addr = r_pc;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (ADDR_W + DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redir_valid),
    .i_wdata ({r_pc, bus.imem_data}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.out_valid = !w_empty;
  assign bus.out_pc    = w_rdata[DATA_W +: ADDR_W];
  assign bus.out_instr = w_rdata[DATA_W-1:0];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed, table-driven bench for imem_fetch_ctrl. Honors
// FETCH_HALT_DETECT_EN for the self-jump expectations.
module tb_imem_fetch_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imem_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus_if ();

  logic [31:0] mem [0:255];
  assign bus_if.imem_data = mem[bus_if.imem_addr];

  imem_fetch_ctrl #(.ADDR_W(8), .DATA_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HD = 1'b1;
`else
  localparam bit HD = 1'b0;
`endif

  typedef struct {
    bit       rst;
    bit       rdy;
    bit       rv;
    bit [7:0] rpc;
    bit       ev;
    bit [7:0] epc;
    bit [7:0] eaddr;
    bit       eh;
  } vec_t;

  vec_t vec[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input bit r, input bit rdy, input bit rv, input bit [7:0] rpc,
                     input bit ev, input bit [7:0] epc, input bit [7:0] eaddr, input bit eh);
    vec_t v;
    v = '{r, rdy, rv, rpc, ev, epc, eaddr, eh};
    vec.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h2000_0000 | i;
    mem[0]  = 32'h0000_4020;
    mem[2]  = 32'h0C00_000F;   // jal 15
    mem[3]  = 32'h8d09_0040;
    mem[18] = 32'h0800_0012;   // j 18 (self-jump)

    rst = 1'b1;
    bus_if.out_ready   = 1'b0;
    bus_if.redir_valid = 1'b0;
    bus_if.redir_pc    = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", {31'd0, bus_if.out_valid}, 32'd0);
    chk("rst halted",    {31'd0, bus_if.halted},    32'd0);
    chk("rst imem_addr", {24'd0, bus_if.imem_addr}, 32'd0);
    chk("rst out_pc",    {24'd0, bus_if.out_pc},    32'd0);
    chk("rst out_instr", bus_if.out_instr,          32'd0);

    // rst rdy rv rpc | ev epc eaddr eh   (expected after the edge)
    // streaming through jal at pc 2
    add(0,1,0,0,     1,0,1,0);
    add(0,1,0,0,     1,1,2,0);
    add(0,1,0,0,     1,2,15,0);
    add(0,1,0,0,     1,15,16,0);
    add(0,1,0,0,     1,16,17,0);
    // backpressure from cycle 1: queue fills, pc frozen at 2
    add(1,0,0,0,     0,0,0,0);
    add(0,0,0,0,     1,0,1,0);
    add(0,0,0,0,     1,0,2,0);
    add(0,0,0,0,     1,0,2,0);
    add(0,0,0,0,     1,0,2,0);
    add(0,1,0,0,     1,1,15,0);
    add(0,1,0,0,     1,2,16,0);
    add(0,1,0,0,     1,15,17,0);
    add(0,0,0,0,     1,15,17,0);   // full with 15,16
    // redirect while full
    add(0,0,1,3,     0,0,3,0);
    add(0,1,0,0,     1,3,4,0);
    // redirect + pop + push in one cycle
    add(0,1,1,20,    0,0,20,0);
    add(0,0,0,0,     1,20,21,0);
    // pc wrap
    add(0,1,1,255,   0,0,255,0);
    add(0,1,0,0,     1,255,0,0);
    add(0,1,0,0,     1,0,1,0);
    // reset mid-stream
    add(1,1,0,0,     0,0,0,0);
    add(0,1,0,0,     1,0,1,0);
    // self-jump at 18
    add(0,1,1,18,    0,0,18,0);
    add(0,1,0,0,     1,18,18,HD);
    add(0,1,0,0,     !HD,18,18,HD);
    add(0,1,0,0,     !HD,18,18,HD);
    add(0,1,1,0,     0,0,0,0);
    add(0,1,0,0,     1,0,1,0);

    for (int i = 0; i < vec.size(); i++) begin
      rst                = vec[i].rst;
      bus_if.out_ready   = vec[i].rdy;
      bus_if.redir_valid = vec[i].rv;
      bus_if.redir_pc    = vec[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), {31'd0, bus_if.out_valid}, {31'd0, vec[i].ev});
      chk($sformatf("v%0d imem_addr", i), {24'd0, bus_if.imem_addr}, {24'd0, vec[i].eaddr});
      chk($sformatf("v%0d halted", i),    {31'd0, bus_if.halted},    {31'd0, vec[i].eh});
      if (vec[i].ev) begin
        chk($sformatf("v%0d out_pc", i),    {24'd0, bus_if.out_pc}, {24'd0, vec[i].epc});
        chk($sformatf("v%0d out_instr", i), bus_if.out_instr,       mem[vec[i].epc]);
      end
    end

    // jal must reach decode unchanged: walk from pc 2 with decode stalled
    bus_if.redir_valid = 1'b1;
    bus_if.redir_pc    = 8'd2;
    bus_if.out_ready   = 1'b0;
    @(posedge clk); #1;
    bus_if.redir_valid = 1'b0;
    @(posedge clk); #1;
    chk("jal out_instr", bus_if.out_instr, 32'h0C00_000F);
    chk("jal next addr", {24'd0, bus_if.imem_addr}, 32'd15);
    @(posedge clk); #1;
    chk("jal hold head", {24'd0, bus_if.out_pc}, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction fetch controller that sequences the asynchronous 256×32 instruction memory. It owns the program counter, drives the memory address, and predecodes unconditional `j`/`jal` so fetch follows them without a bubble. It buffers fetched {pc, instr} pairs in a 2-entry queue with a valid/ready handshake toward decode. It also accepts redirects (branch, `jr`) from execute, which flush the queue.

## Interface
- ADDR_W, 8, word-address width of instruction memory (256 words)
- DATA_W, 32, instruction width
- DEPTH, 2, fetch queue entries (power of two, ≥2)

- clk  input  1  single clock, rising edge
- rst  input  1  reset, synchronous, active-high
- imem_addr  output  ADDR_W  word address to instruction memory (combinational from pc)
- imem_data  input  DATA_W  instruction returned combinationally by memory
- redir_valid  input  1  execute-stage redirect request
- redir_pc  input  ADDR_W  redirect target word address
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head
- out_instr  output  DATA_W  head instruction
- out_pc  output  ADDR_W  head instruction word address
- halted  output  1  fetch stopped on self-jump (see Configuration)

## Operation
- States: FETCH, FULL, HALTED. Reset → FETCH, pc=0, queue empty.
- FETCH: imem_addr=pc. Each cycle with queue not full (after any same-cycle pop), push {pc, imem_data} and advance pc.
- Next pc: opcode = instr[31:26]. For 6'h02 (`j`) or 6'h03 (`jal`), next pc = instr[ADDR_W-1:0]. Otherwise pc+1, wrapping modulo 2^ADDR_W (255 → 0).
- `jal` is queued unchanged. Decode/execute writes $ra using out_pc+1.
- FULL: entered when the queue holds DEPTH entries and no pop occurs. No fetch and pc held. Returns to FETCH in the cycle a pop occurs; push and pop in the same cycle are allowed.
- Pop: out_valid & out_ready at the edge.
- Redirect: redir_valid at an edge clears the queue, sets pc=redir_pc and enters FETCH from any state. It has priority over a same-cycle push, pop or halt detection; the instruction fetched in that cycle is discarded.
- Queue ordering: strict FIFO. out_* come from registered queue storage, not from imem_data.

## Timing
- Reset values: out_valid=0, halted=0, imem_addr=0 (pc=0). out_instr/out_pc=0.
- Reset mid-operation behaves identically to redirect to 0, and also clears halted.
- Fetch-to-decode latency: 1 cycle. The instruction at imem_addr in cycle N appears with out_valid in cycle N+1.
- First valid after rst deasserts: cycle 1 (pc 0).
- Redirect at edge N: out_valid=0 in cycle N+1. The target instruction is presented in cycle N+2.
- Sustained throughput: 1 instruction/cycle while out_ready=1, including across `j`/`jal` (zero bubbles).
- imem_addr changes only at clock edges.

## Configuration
- FETCH_HALT_DETECT_EN defined:
  - An instruction with opcode 6'h02 whose target equals its own pc is pushed normally, then the controller enters HALTED.
  - In HALTED: no further fetch, pc held, halted=1 from the next cycle.
  - The queue still drains to decode.
  - Only redir_valid or rst leaves HALTED.
- Not defined: HALTED state absent, halted tied 0, and self-jumps are fetched repeatedly like any `j`.

## Structure
- Shared package/include `fetch_pkg`: OP_J=6'h02, OP_JAL=6'h03, opcode field bounds, state encoding localparams.
- One sub-module, `fetch_fifo`: DEPTH×(DATA_W+ADDR_W) synchronous FIFO with push, pop, flush, full and empty. Flush has priority over push and pop.
- Controller holds pc, state and next-pc/predecode logic.

## Test plan
- Reset then out_ready=1, memory word 0=32'h00004020, word 2=32'h0C00000F → out_pc sequence 0,1,2,15,16 on consecutive cycles, no bubbles.
- out_ready=0 from cycle 1 → two entries (pc 0,1) held, imem_addr frozen at 2. Raise out_ready → pc 0,1,2 emerge in order, nothing lost or duplicated.
- redir_valid with redir_pc=3 while queue full (pc 15,16) → cycle N+1 out_valid=0, cycle N+2 out_pc=3 with instr 32'h8d090040.
- Simultaneous redirect, pop and push in one cycle → queue empty next cycle, no stale entry popped afterwards, pc=redir_pc.
- Self-jump 32'h08000012 at word 18, macro defined → pc 18 delivered once, halted=1, imem_addr stays 18. Redirect to 0 clears halted. Macro undefined → pc 18 delivered every cycle.
- pc wrap: redirect to 255 with non-jump contents → next out_pc 255 then 0. Assert rst mid-stream → next cycle out_valid=0, pc=0.
